// File: rtl/keypad_pkg.sv
// Shared widths, key-code constants, FSM state type and the one-hot key encoder
// used by the keypad front end.
package keypad_pkg;

  localparam int KEY_W  = 12;
  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] KEY_STAR = 4'd10;
  localparam logic [CODE_W-1:0] KEY_HASH = 4'd11;

  typedef enum logic {IDLE, HELD} state_t;

  typedef struct packed {
    logic              onehot;
    logic [CODE_W-1:0] code;
  } enc_t;

  // Key line index to key code: lines 0..8 are digits 1..9, then *, 0, #.
  function automatic logic [CODE_W-1:0] key_map(input int idx);
    logic [CODE_W-1:0] c;
    if (idx < 9)       c = CODE_W'(idx + 1);
    else if (idx == 9) c = KEY_STAR;
    else if (idx == 10) c = '0;
    else               c = KEY_HASH;
    return c;
  endfunction

  function automatic enc_t encode(input logic [KEY_W-1:0] v);
    enc_t       r;
    logic [3:0] n;
    r = '0;
    n = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (v[i]) begin
        n      = n + 4'd1;
        r.code = key_map(i);
      end
    end
    r.onehot = (n == 4'd1);
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy counter. A push into a full FIFO
// succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Storage is reset so the head reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Keypad front end: synchronise, debounce, turn clean single-key presses into
// one key-code event each, and queue events for a valid/ready consumer.
module keypad_event_ctrl
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [KEY_W-1:0]            keypad_in,
  output logic [CODE_W-1:0]           key_code,
  output logic                        key_valid,
  input  logic                        key_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_ovf,
  output state_t                      fsm_state
);

  // Handshake: the head entry transfers on a cycle where key_valid && key_ready
  // at the rising edge; key_valid never depends on key_ready, and key_ready
  // while key_valid is low has no effect.

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [KEY_W-1:0] s1, s, cand, deb;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  enc_t             enc;
  logic             push, full, empty, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= keypad_in;
      s  <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand <= '0;
      cnt  <= '0;
      deb  <= '0;
    end else if (en) begin
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (cnt == CNT_MAX) deb <= cand;
      end
    end
  end

  assign enc  = encode(deb);
  assign push = en && (state == IDLE) && enc.onehot;
  assign pop  = key_valid & key_ready;

  // Any non-zero vector leaves IDLE; chords do so without emitting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (en) begin
      case (state)
        IDLE:    if (deb != '0) state <= HELD;
        HELD:    if (deb == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
    else if (clr_ovf)            overflow <= 1'b0;
  end

  sync_fifo #(
    .W     (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (enc.code),
    .pop   (pop),
    .rdata (key_code),
    .empty (empty),
    .full  (full),
    .level (fifo_level)
  );

  assign key_valid = ~empty;
  assign fsm_state = state;

endmodule
